// File: rtl/lut_cfg_pkg.sv
// Shared constants and state encoding for the LUT configuration loader.
package lut_cfg_pkg;

  localparam int unsigned LUT_K_DEF = 4;
  localparam int unsigned LUT_DEPTH = 2 ** LUT_K_DEF;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    COMMIT,
    REPORT
  } state_e;

endpackage

// File: rtl/lut_cfg_shreg.sv
// Indexed shadow store for one truth table plus a running parity of the bits written this frame.
module lut_cfg_shreg
  import lut_cfg_pkg::*;
#(
  parameter int unsigned LUT_K = LUT_K_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_par,
  input  logic             wr_en,
  input  logic [LUT_K-1:0] wr_idx,
  input  logic             wr_bit,
  input  logic [LUT_K-1:0] rd_idx,
  output logic             rd_bit_c,
  output logic             par_odd
);

  localparam int unsigned DEPTH = 2 ** LUT_K;

  logic [DEPTH-1:0] shadow_q;

  // Every entry is rewritten once per frame, so the XOR of this frame's bits equals popcount parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      par_odd  <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_q[wr_idx] <= wr_bit;
      end
      if (clr_par) begin
        par_odd <= 1'b0;
      end else if (wr_en) begin
        par_odd <= par_odd ^ wr_bit;
      end
    end
  end

  assign rd_bit_c = shadow_q[rd_idx];

endmodule

// File: rtl/lut_cfg_loader.sv
// Serial truth-table loader: shifts in a frame, checks odd parity, then replays it onto the LUT write port.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int unsigned LUT_K = LUT_K_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic             s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [LUT_K-1:0] cfg_addr,
  output logic             cfg_data,
  output logic             cfg_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned DEPTH = 2 ** LUT_K;
  localparam int unsigned CW    = LUT_K + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LUT_K-1:0] cfg_addr_d;
  logic             cfg_data_d, cfg_en_d, done_d, err_d, s_ready_d, busy_d;
  logic             accept, wr_en, clr_par, rd_bit_c, par_odd;
  logic [LUT_K-1:0] rd_idx;

  assign accept = s_valid && s_ready;
  assign rd_idx = (state_q == COMMIT) ? cnt_q[LUT_K-1:0] : '0;

  lut_cfg_shreg #(.LUT_K(LUT_K)) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_par  (clr_par),
    .wr_en    (wr_en),
    .wr_idx   (cnt_q[LUT_K-1:0]),
    .wr_bit   (s_data),
    .rd_idx   (rd_idx),
    .rd_bit_c (rd_bit_c),
    .par_odd  (par_odd)
  );

  // State, counter and all outputs are registered from their next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cfg_addr <= '0;
      cfg_data <= 1'b0;
      cfg_en   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cfg_addr <= cfg_addr_d;
      cfg_data <= cfg_data_d;
      cfg_en   <= cfg_en_d;
      done     <= done_d;
      err      <= err_d;
      s_ready  <= s_ready_d;
      busy     <= busy_d;
    end
  end

  // Next state; the write port presents entry cnt_q-1 while cnt_q runs 1..DEPTH in COMMIT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_addr_d = '0;
    cfg_data_d = 1'b0;
    cfg_en_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    clr_par    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d = SHIFT;
          cnt_d   = '0;
          clr_par = 1'b1;
        end
      end
      SHIFT: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (accept) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DEPTH - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (par_odd ^ s_data) begin
            state_d    = COMMIT;
            cnt_d      = CW'(1);
            cfg_en_d   = 1'b1;
            cfg_data_d = rd_bit_c;
          end else begin
            state_d = REPORT;
            err_d   = 1'b1;
          end
        end
      end
      COMMIT: begin
        if (cnt_q == CW'(DEPTH)) begin
          state_d = REPORT;
          done_d  = 1'b1;
        end else begin
          cfg_en_d   = 1'b1;
          cfg_addr_d = cnt_q[LUT_K-1:0];
          cfg_data_d = rd_bit_c;
          cnt_d      = cnt_q + CW'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d = (state_d == SHIFT) || (state_d == PARITY);
    busy_d    = (state_d != IDLE);
  end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed/random bench for lut_cfg_loader against a frame-level model (popcount parity, expected write sequence).
module tb_lut_cfg_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0, cfg_abort = 1'b0, s_data = 1'b0, s_valid = 1'b0;
  logic       s_ready, cfg_data, cfg_en, busy, done, err;
  logic [3:0] cfg_addr;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_count = 0;
  int done_count = 0;

  lut_cfg_loader #(.LUT_K(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_en    (cfg_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cfg_en) wr_count <= wr_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; abort_after>=0 aborts after that many accepted bits, rst_at>=0 resets in that commit cycle.
  task automatic run_frame(input logic [15:0] d, input logic p, input int unsigned gap_pct,
                           input int abort_after, input int rst_at);
    logic [16:0] bits;
    int          i, budget, wc0, dc0;
    bit          odd;
    bits   = {p, d};
    i      = 0;
    budget = 0;
    wc0    = wr_count;
    dc0    = done_count;
    odd    = ((($countones(d) + int'(p)) % 2) == 1);

    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("start_busy_ready", {30'd0, busy, s_ready}, 32'h3);

    while (i < 17 && budget < 2000) begin
      if (abort_after >= 0 && i == abort_after) begin
        cfg_abort = 1'b1;
        cfg_start = 1'b1;
        s_valid   = 1'($urandom);
        s_data    = bits[i];
        tick();
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        s_valid   = 1'b0;
        chk("abort_idle", {30'd0, busy, s_ready}, 32'h0);
        repeat (3) tick();
        chk("abort_no_write", 32'(wr_count), 32'(wc0));
        chk("abort_no_report", 32'(done_count), 32'(dc0));
        return;
      end
      s_valid   = ($urandom_range(99) >= gap_pct);
      s_data    = bits[i];
      cfg_start = 1'($urandom);
      tick();
      if (s_valid) i++;
      budget++;
    end
    cfg_start = 1'b0;
    if (i < 17) begin
      chk("frame_timeout", 32'(i), 32'd17);
      s_valid = 1'b0;
      return;
    end

    if (odd) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("commit_%0d", k), {25'd0, s_ready, cfg_en, cfg_addr, cfg_data, done, err},
            {25'd0, 1'b0, 1'b1, 4'(k), d[k], 1'b0, 1'b0});
        if (k == rst_at) begin
          #2 rst_n = 1'b0;
          #1;
          chk("async_rst_outputs", {25'd0, s_ready, cfg_en, busy, cfg_addr}, 32'h0);
          @(posedge clk);
          #1 rst_n = 1'b1;
          s_valid = 1'b0;
          repeat (20) tick();
          chk("rst_no_done", 32'(done_count), 32'(dc0));
          chk("rst_idle", {30'd0, busy, cfg_en}, 32'h0);
          return;
        end
        s_valid = 1'($urandom);
        s_data  = 1'($urandom);
        tick();
      end
      chk("done_cycle", {27'd0, cfg_en, busy, s_ready, done, err}, {27'd0, 5'b01010});
      s_valid = 1'($urandom);
      tick();
      chk("after_done", {27'd0, cfg_en, busy, s_ready, done, err}, 32'h0);
      chk("write_count", 32'(wr_count - wc0), 32'd16);
    end else begin
      chk("err_cycle", {27'd0, cfg_en, busy, s_ready, done, err}, {27'd0, 5'b01001});
      tick();
      chk("after_err", {27'd0, cfg_en, busy, s_ready, done, err}, 32'h0);
      chk("err_no_write", 32'(wr_count - wc0), 32'd0);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    for (int c = 0; c < 3; c++) begin
      cfg_start = 1'($urandom);
      cfg_abort = 1'($urandom);
      s_valid   = 1'($urandom);
      s_data    = 1'($urandom);
      tick();
      chk("reset_outputs", {25'd0, s_ready, cfg_en, cfg_addr, cfg_data, busy, done, err}, 32'h0);
    end
    cfg_start = 1'b0;
    rst_n = 1'b1;
    // Idle with random s_valid: nothing happens, nothing consumed
    for (int c = 0; c < 10; c++) begin
      s_valid   = 1'($urandom);
      s_data    = 1'($urandom);
      cfg_abort = 1'($urandom);
      tick();
    end
    s_valid   = 1'b0;
    cfg_abort = 1'b0;
    chk("idle_no_activity", {31'd0, busy}, 32'h0);
    chk("idle_no_write", 32'(wr_count), 32'd0);

    // Start together with abort is ignored
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("start_abort_ignored", {30'd0, busy, s_ready}, 32'h0);

    run_frame(16'hA5C3, 1'b1, 0, -1, -1);
    run_frame(16'h0001, 1'b1, 0, -1, -1);
    run_frame(16'hFFFF, 1'b1, 50, -1, -1);
    run_frame(16'h1234, 1'b0, 0, 7, -1);
    run_frame(16'h8000, 1'b0, 0, -1, -1);
    run_frame(16'h5A5A, 1'b1, 20, -1, 4);
    for (int f = 0; f < 4; f++) begin
      run_frame(16'($urandom), 1'($urandom), 30, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d assertions", n_chk);
    $fatal(1);
  end

endmodule
